// File: rtl/mac_share_sched_if.sv
// Requester, shared-multiplier and response signals of mac_share_sched.
// The slave view belongs to the scheduler; the master view belongs to its environment.
interface mac_share_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 31,
    parameter int unsigned BW   = 16
);
    localparam int unsigned ACCW = AW + BW + 2;
    localparam int unsigned IDW  = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  op_flat;
    logic [AW*NREQ-1:0] a_flat;
    logic [BW*NREQ-1:0] b_flat;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      mul_a;
    logic [BW-1:0]      mul_b;
    logic               mul_go;
    logic [AW+BW-1:0]   mul_p;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [ACCW-1:0]    rsp_data;

    modport master (
        output req, op_flat, a_flat, b_flat, mul_p, rsp_ready,
        input  gnt, mul_a, mul_b, mul_go, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req, op_flat, a_flat, b_flat, mul_p, rsp_ready,
        output gnt, mul_a, mul_b, mul_go, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mac_share_sched.sv
// Round-robin scheduler sharing one fixed-latency multiplier between NREQ requesters,
// with a private accumulator per requester and a valid/ready response port.
module mac_share_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 31,
    parameter int unsigned BW   = 16,
    parameter int unsigned LAT  = 2
) (
    input logic             clk,
    input logic             rst,
    mac_share_sched_if.slave bus
);
    localparam int unsigned ACCW = AW + BW + 2;
    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned CW   = $clog2(LAT + 1);

    localparam logic [1:0] OP_MAC = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    id_q;
    logic [IDW-1:0]    win;
    logic [IDW-1:0]    idx;
    logic              win_found;
    logic              grant;
    logic              take_p;
    logic              rsp_fire;
    logic [1:0]        win_op;
    logic [1:0]        op_q;
    logic [AW-1:0]     win_a;
    logic [AW-1:0]     a_q;
    logic [BW-1:0]     win_b;
    logic [BW-1:0]     b_q;
    logic [CW-1:0]     cnt_q;
    logic              mul_go_q;
    logic              rsp_valid_q;
    logic [ACCW-1:0]   rsp_data_q;
    logic [ACCW-1:0]   mac_sum;
    logic [NREQ-1:0]   gnt_vec;
    logic [ACCW-1:0]   acc [NREQ];

    // First requesting index at or above ptr, wrapping around.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = IDW'((int'(ptr_q) + k) % int'(NREQ));
            if (!win_found && bus.req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    assign win_op  = bus.op_flat[2*int'(win) +: 2];
    assign win_a   = bus.a_flat[AW*int'(win) +: AW];
    assign win_b   = bus.b_flat[BW*int'(win) +: BW];
    assign mac_sum = acc[id_q] + ACCW'(bus.mul_p);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        take_p   = 1'b0;
        rsp_fire = 1'b0;
        gnt_vec  = '0;
        case (state_q)
            IDLE: begin
                if (win_found && !rst) begin
                    grant        = 1'b1;
                    gnt_vec[win] = 1'b1;
                    state_d      = (win_op == OP_CLR) ? RESP : ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    take_p  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Job latch, multiplier issue, result formation and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            id_q        <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            mul_go_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            for (int i = 0; i < int'(NREQ); i++) begin
                acc[i] <= '0;
            end
        end else begin
            mul_go_q <= 1'b0;
            if (grant) begin
                id_q <= win;
                op_q <= win_op;
                if (win_op == OP_CLR) begin
                    acc[win]    <= '0;
                    rsp_data_q  <= '0;
                    rsp_valid_q <= 1'b1;
                end else begin
                    a_q      <= win_a;
                    b_q      <= win_b;
                    mul_go_q <= 1'b1;
                end
            end
            // Counter is loaded in ISSUE so the product is taken LAT cycles after mul_go.
            if (state_q == ISSUE) begin
                cnt_q <= CW'(LAT);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (take_p) begin
                if (op_q == OP_MAC) begin
                    acc[id_q]  <= mac_sum;
                    rsp_data_q <= mac_sum;
                end else begin
                    rsp_data_q <= ACCW'(bus.mul_p);
                end
                rsp_valid_q <= 1'b1;
            end
            if (rsp_fire) begin
                rsp_valid_q <= 1'b0;
                ptr_q       <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
            end
        end
    end

    assign bus.gnt       = gnt_vec;
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
    assign bus.mul_go    = mul_go_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_mac_share_sched.sv
// Directed bench for mac_share_sched: table of single jobs plus hand-written
// round-robin, back-pressure and mid-job reset sequences.
module tb_mac_share_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 31;
    localparam int unsigned BW   = 16;
    localparam int unsigned LAT  = 2;
    localparam int unsigned PW   = AW + BW;
    localparam int unsigned ACCW = AW + BW + 2;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_MAC = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_ALT = 2'b11;

    // (2^31-1)*(2^16-1) and its running sums, wrapping modulo 2^49.
    localparam logic [ACCW-1:0] P1 = 49'h7FFF_7FFF_0001;
    localparam logic [ACCW-1:0] P2 = 49'hFFFE_FFFE_0002;
    localparam logic [ACCW-1:0] P3 = 49'h1_7FFE_7FFD_0003;
    localparam logic [ACCW-1:0] P4 = 49'(64'h2_0000_0000_0000 - 64'h2_0000_0000 - 64'h4_0000 + 64'd4);
    localparam logic [ACCW-1:0] P5 = 49'(64'h8000_0000_0000 - 64'h2_8000_0000 - 64'h5_0000 + 64'd5);

    typedef struct {
        logic [1:0]      id;
        logic [1:0]      op;
        logic [AW-1:0]   a;
        logic [BW-1:0]   b;
        logic [ACCW-1:0] exp_data;
        int              exp_lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [PW-1:0] p0;
    logic [PW-1:0] p1;
    vec_t          tbl [12];

    mac_share_sched_if #(.NREQ(NREQ), .AW(AW), .BW(BW)) bus ();

    mac_share_sched #(.NREQ(NREQ), .AW(AW), .BW(BW), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: product valid exactly two cycles after mul_go, junk otherwise.
    always @(posedge clk) begin
        p0 <= bus.mul_go ? PW'(bus.mul_a) * PW'(bus.mul_b) : 47'h1234_5678_9ABC;
        p1 <= p0;
    end
    assign bus.mul_p = p1;

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, want finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] id, input logic [1:0] op, input logic [AW-1:0] a,
                                input logic [BW-1:0] b, input logic [ACCW-1:0] e, input int lat);
        vec_t v;
        v.id       = id;
        v.op       = op;
        v.a        = a;
        v.b        = b;
        v.exp_data = e;
        v.exp_lat  = lat;
        return v;
    endfunction

    function automatic int gnt_idx(input logic [NREQ-1:0] g);
        gnt_idx = -1;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (g[i]) gnt_idx = i;
        end
    endfunction

    task automatic set_job(input logic [1:0] id, input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [BW-1:0] b);
        bus.op_flat[2*int'(id) +: 2] = op;
        bus.a_flat[AW*int'(id) +: AW] = a;
        bus.b_flat[BW*int'(id) +: BW] = b;
    endtask

    // Entered and left one time unit after a rising edge, with the scheduler idle.
    task automatic run_job(input vec_t v, input string tag);
        int n;
        int go_cnt;
        int go_at;
        int rv_at;
        int gnt_extra;
        set_job(v.id, v.op, v.a, v.b);
        bus.req[v.id] = 1'b1;
        #1;
        n = 0;
        while (bus.gnt == '0 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check({tag, "_gnt"}, 64'(bus.gnt), 64'd1 << v.id);
        go_cnt = 0; go_at = -1; rv_at = -1; gnt_extra = 0;
        for (int c = 1; c <= 12 && rv_at < 0; c++) begin
            @(posedge clk); #1;
            bus.req[v.id] = 1'b0;
            #1;
            if (bus.mul_go) begin
                go_cnt++;
                if (go_at < 0) go_at = c;
            end
            if (bus.gnt != '0) gnt_extra++;
            if (bus.rsp_valid) rv_at = c;
        end
        check({tag, "_lat"}, 64'(rv_at), 64'(v.exp_lat));
        check({tag, "_go_cnt"}, 64'(go_cnt), (v.op == OP_CLR) ? 64'd0 : 64'd1);
        if (v.op != OP_CLR) check({tag, "_go_at"}, 64'(go_at), 64'd1);
        check({tag, "_extra_gnt"}, 64'(gnt_extra), 64'd0);
        check({tag, "_id"}, 64'(bus.rsp_id), 64'(v.id));
        check({tag, "_data"}, 64'(bus.rsp_data), 64'(v.exp_data));
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int ng;
        int gid [6];
        int gcyc [6];

        rst           = 1'b1;
        bus.req       = '0;
        bus.op_flat   = '0;
        bus.a_flat    = '0;
        bus.b_flat    = '0;
        bus.rsp_ready = 1'b1;

        tbl[0]  = mk(2'd0, OP_MUL, 31'd1000, 16'd3, 49'd3000, 4);
        tbl[1]  = mk(2'd2, OP_MAC, 31'd5, 16'd7, 49'd35, 4);
        tbl[2]  = mk(2'd2, OP_MAC, 31'd5, 16'd7, 49'd70, 4);
        tbl[3]  = mk(2'd2, OP_CLR, 31'd5, 16'd7, 49'd0, 1);
        tbl[4]  = mk(2'd2, OP_MAC, 31'd2, 16'd3, 49'd6, 4);
        tbl[5]  = mk(2'd1, OP_ALT, 31'd12, 16'd12, 49'd144, 4);
        tbl[6]  = mk(2'd0, OP_MUL, 31'h7FFF_FFFF, 16'hFFFF, P1, 4);
        tbl[7]  = mk(2'd3, OP_MAC, 31'h7FFF_FFFF, 16'hFFFF, P1, 4);
        tbl[8]  = mk(2'd3, OP_MAC, 31'h7FFF_FFFF, 16'hFFFF, P2, 4);
        tbl[9]  = mk(2'd3, OP_MAC, 31'h7FFF_FFFF, 16'hFFFF, P3, 4);
        tbl[10] = mk(2'd3, OP_MAC, 31'h7FFF_FFFF, 16'hFFFF, P4, 4);
        tbl[11] = mk(2'd3, OP_MAC, 31'h7FFF_FFFF, 16'hFFFF, P5, 4);

        repeat (2) @(posedge clk);
        #2;
        check("reset_gnt", 64'(bus.gnt), 64'd0);
        check("reset_mul_go", 64'(bus.mul_go), 64'd0);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_mul_a", 64'(bus.mul_a), 64'd0);
        check("reset_mul_b", 64'(bus.mul_b), 64'd0);
        check("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_job(tbl[i], $sformatf("vec%0d", i));
        end

        // All four requesters held high; pointer starts at 0 after requester 3 finished.
        for (int i = 0; i < 4; i++) begin
            set_job(2'(i), OP_MUL, AW'(i + 1), BW'(10));
        end
        bus.req = 4'hF;
        #1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            if (bus.gnt != '0) begin
                gid[ng]  = gnt_idx(bus.gnt);
                gcyc[ng] = c;
                ng++;
            end
            if (bus.rsp_valid) begin
                check("rr_rsp_data", 64'(bus.rsp_data), 64'(bus.rsp_id) * 64'd10 + 64'd10);
            end
            @(posedge clk); #2;
        end
        bus.req = '0;
        check("rr_grant_count", 64'(ng), 64'd6);
        for (int k = 0; k < ng; k++) begin
            check($sformatf("rr_order%0d", k), 64'(gid[k]), 64'(k % 4));
            if (k > 0) check($sformatf("rr_spacing%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'd5);
        end
        repeat (8) @(posedge clk);
        #1;

        // Back-pressure: response held, waiting requester 0 stays ungranted until the handshake.
        bus.rsp_ready = 1'b0;
        set_job(2'd1, OP_MUL, 31'd9, 16'd9);
        bus.req = 4'b0010;
        #1;
        n = 0;
        while (bus.gnt == '0 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check("bp_gnt1", 64'(bus.gnt), 64'd2);
        @(posedge clk); #1;
        set_job(2'd0, OP_MUL, 31'd2, 16'd2);
        bus.req = 4'b0001;
        #1;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check("bp_valid_lat", 64'(n), 64'd3);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_hold_data", 64'(bus.rsp_data), 64'd81);
            check("bp_hold_id", 64'(bus.rsp_id), 64'd1);
            check("bp_hold_no_gnt", 64'(bus.gnt), 64'd0);
            @(posedge clk); #2;
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_hs_valid", 64'(bus.rsp_valid), 64'd1);
        check("bp_hs_no_gnt", 64'(bus.gnt), 64'd0);
        @(posedge clk); #2;
        check("bp_gnt0_after_hs", 64'(bus.gnt), 64'd1);
        check("bp_valid_dropped", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;
        bus.req = '0;
        #1;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check("bp_job0_id", 64'(bus.rsp_id), 64'd0);
        check("bp_job0_data", 64'(bus.rsp_data), 64'd4);
        @(posedge clk); #1;

        // Reset during WAIT of a requester-0 MAC with acc0 = 100.
        run_job(mk(2'd0, OP_CLR, 31'd0, 16'd0, 49'd0, 1), "rst_pre_clr");
        run_job(mk(2'd0, OP_MAC, 31'd10, 16'd10, 49'd100, 4), "rst_pre_mac");
        set_job(2'd0, OP_MAC, 31'd4, 16'd4);
        bus.req = 4'b0001;
        #1;
        check("rst_gnt0", 64'(bus.gnt), 64'd1);
        @(posedge clk); #1;
        bus.req = '0;
        #1;
        check("rst_issue_go", 64'(bus.mul_go), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        set_job(2'd1, OP_MUL, 31'd3, 16'd3);
        bus.req = 4'b0010;
        #1;
        check("rst_in_reset_gnt", 64'(bus.gnt), 64'd0);
        check("rst_in_reset_valid", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_after_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_after_mul_a", 64'(bus.mul_a), 64'd0);
        check("rst_after_gnt1", 64'(bus.gnt), 64'd2);
        @(posedge clk); #1;
        bus.req = '0;
        #1;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check("rst_job1_lat", 64'(n), 64'd3);
        check("rst_job1_id", 64'(bus.rsp_id), 64'd1);
        check("rst_job1_data", 64'(bus.rsp_data), 64'd9);
        @(posedge clk); #1;
        run_job(mk(2'd0, OP_MAC, 31'd4, 16'd4, 49'd16, 4), "rst_acc0_cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
